// File: rtl/mix_columns_engine.sv
// mix_columns_engine
//   Iterative AES MixColumns / InvMixColumns engine. A 128-bit state is
//   captured on accept, transformed COLS_PER_CYCLE columns per cycle in
//   place, then presented on out_state until the downstream handshake.
//
// Parameters
//   COLS_PER_CYCLE : columns transformed per cycle (1, 2 or 4)
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : input block offered
//   in_ready   : engine idle and able to accept
//   in_state   : AES state, column i = bits i*32..i*32+31, row j = byte j
//   inverse    : 0 = MixColumns, 1 = InvMixColumns
//   bypass     : (only with MIXCOL_BYPASS_EN) pass block through unchanged
//   out_valid  : result available
//   out_ready  : downstream accepts result
//   out_state  : result, same layout as in_state
//
// Optional feature macro: MIXCOL_BYPASS_EN
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_state,
    input  logic         inverse,
`ifdef MIXCOL_BYPASS_EN
    input  logic         bypass,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Counter value at the start of the cycle that handles column 3.
    localparam logic [2:0] LAST_CNT = 3'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [0:127] data_q, data_d;
    logic         inv_q, inv_d;
    logic         out_valid_q, out_valid_d;
    logic [0:127] out_state_q, out_state_d;
    logic         xform;

`ifdef MIXCOL_BYPASS_EN
    logic         byp_q, byp_d;
    assign xform = ~byp_q;
`else
    assign xform = 1'b1;
`endif

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column; byte 0 (row 0) sits in bits [31:24].
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] s [4];
        logic [7:0] m2[4], m3[4], m4[4], m8[4], m9[4], mb[4], md[4], me[4];
        logic [31:0] r;
        for (int j = 0; j < 4; j++) begin
            s[j]  = c[31-8*j -: 8];
            m2[j] = xt(s[j]);
            m4[j] = xt(m2[j]);
            m8[j] = xt(m4[j]);
            m3[j] = m2[j] ^ s[j];
            m9[j] = m8[j] ^ s[j];
            mb[j] = m8[j] ^ m2[j] ^ s[j];
            md[j] = m8[j] ^ m4[j] ^ s[j];
            me[j] = m8[j] ^ m4[j] ^ m2[j];
        end
        r = '0;
        for (int j = 0; j < 4; j++) begin
            if (inv)
                r[31-8*j -: 8] = me[j] ^ mb[2'(j+1)] ^ md[2'(j+2)] ^ m9[2'(j+3)];
            else
                r[31-8*j -: 8] = m2[j] ^ m3[2'(j+1)] ^ s[2'(j+2)] ^ s[2'(j+3)];
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        inv_d       = inv_q;
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
`ifdef MIXCOL_BYPASS_EN
        byp_d       = byp_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = BUSY;
                    cnt_d   = 2'd0;
                    data_d  = in_state;
                    inv_d   = inverse;
`ifdef MIXCOL_BYPASS_EN
                    byp_d   = bypass;
`endif
                end
            end
            BUSY: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    if (xform)
                        data_d[(int'(cnt_q) + k) * 32 +: 32] =
                            mix_col(data_q[(int'(cnt_q) + k) * 32 +: 32], inv_q);
                end
                cnt_d = cnt_q + 2'(COLS_PER_CYCLE);
                if ({1'b0, cnt_q} == LAST_CNT) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_state_d = data_d;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
`ifdef MIXCOL_BYPASS_EN
            byp_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            inv_q       <= inv_d;
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
`ifdef MIXCOL_BYPASS_EN
            byp_q       <= byp_d;
`endif
        end
    end

    // Held low during reset so nothing is offered an accept that reset discards.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Self-checking bench: three engines (COLS_PER_CYCLE 1, 2, 4) share inputs.
module tb_mix_columns_engine;

    localparam logic [0:127] V1 = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
    localparam logic [0:127] E1 = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};
    localparam logic [0:127] V2 = {32'hd4d4d4d5, 32'h2d26314c, 32'h00000000, 32'h5c5c5c5c};
    localparam logic [0:127] E2 = {32'hd5d5d7d6, 32'h4d7ebdf8, 32'h00000000, 32'h5c5c5c5c};
    localparam logic [0:127] VB = {4{32'hdb135345}};
    localparam logic [0:127] EB = {4{32'h8e4da1bc}};

    logic         clk, rst, in_valid, inverse, out_ready, bypass;
    logic [0:127] in_state;
    logic         in_ready_w  [3];
    logic         out_valid_w [3];
    logic [0:127] out_state_w [3];

    int           pass_cnt = 0;
    int           total    = 0;
    int           cpc [3]  = '{1, 2, 4};
    logic [0:127] res_r  [3];
    int           lat_r  [3];
    logic         post_r [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_engine #(.COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .in_state  (in_state),
            .inverse   (inverse),
`ifdef MIXCOL_BYPASS_EN
            .bypass    (bypass),
`endif
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .out_state (out_state_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(in_ready_w[0] && in_ready_w[1] && in_ready_w[2]) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            total++;
            $display("FAIL wait_ready: engines not idle after %0d cycles", n);
        end
    endtask

    // Offers one block with out_ready=1; records result, latency and whether
    // in_ready=1 / out_valid=0 one cycle after the output handshake.
    task automatic run_block(input logic [0:127] st, input logic inv, input logic byp);
        logic got [3];
        logic pd  [3];
        wait_ready();
        for (int d = 0; d < 3; d++) begin
            got[d] = 0; pd[d] = 0; lat_r[d] = -1; res_r[d] = 'x; post_r[d] = 0;
        end
        in_valid = 1; in_state = st; inverse = inv; bypass = byp; out_ready = 1;
        tick();
        in_valid = 0; in_state = ~st; inverse = ~inv; bypass = ~byp;
        for (int c = 1; c <= 12; c++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                if (got[d] && !pd[d]) begin
                    pd[d] = 1;
                    post_r[d] = in_ready_w[d] && !out_valid_w[d];
                end
                if (!got[d] && out_valid_w[d]) begin
                    got[d] = 1; lat_r[d] = c; res_r[d] = out_state_w[d];
                end
            end
            if (pd[0] && pd[1] && pd[2]) break;
        end
    endtask

    task automatic check_res(input string name, input logic [0:127] exp);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (res_r[d] !== exp)
                $display("FAIL %s C=%0d got %h exp %h", name, cpc[d], res_r[d], exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; in_state = '0; inverse = 0; out_ready = 1; bypass = 0;
        tick(); tick();
        for (int d = 0; d < 3; d++) begin
            total++;
            if (out_valid_w[d] !== 1'b0 || out_state_w[d] !== '0 || in_ready_w[d] !== 1'b0)
                $display("FAIL reset_hold C=%0d got ov=%b os=%h rdy=%b exp 0/0/0",
                         cpc[d], out_valid_w[d], out_state_w[d], in_ready_w[d]);
            else pass_cnt++;
        end
        rst = 0;
        #1;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (in_ready_w[d] !== 1'b1)
                $display("FAIL reset_release C=%0d got rdy=%b exp 1", cpc[d], in_ready_w[d]);
            else pass_cnt++;
        end
    endtask

    task automatic test_forward();
        run_block(V1, 0, 0); check_res("fwd_v1", E1);
        run_block(V2, 0, 0); check_res("fwd_v2", E2);
    endtask

    task automatic test_inverse();
        run_block(E1, 1, 0); check_res("inv_e1", V1);
        run_block(E2, 1, 0); check_res("inv_e2", V2);
    endtask

    task automatic test_roundtrip();
        logic [0:127] r;
        for (int i = 0; i < 2; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            run_block(r, 0, 0);
            run_block(res_r[0], 1, 0);
            check_res("roundtrip", r);
        end
    endtask

    task automatic test_latency();
        run_block(V2, 0, 0);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (lat_r[d] !== 4 / cpc[d])
                $display("FAIL latency C=%0d got %0d exp %0d", cpc[d], lat_r[d], 4 / cpc[d]);
            else pass_cnt++;
            total++;
            if (post_r[d] !== 1'b1)
                $display("FAIL ready_after_hs C=%0d got %b exp 1", cpc[d], post_r[d]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic ok [3];
        wait_ready();
        out_ready = 0; in_valid = 1; in_state = V1; inverse = 0;
        tick();
        in_valid = 0;
        repeat (5) tick();
        for (int d = 0; d < 3; d++) ok[d] = 1;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'($urandom); inverse = 1'($urandom);
            in_state = {$urandom, $urandom, $urandom, $urandom};
            tick();
            for (int d = 0; d < 3; d++)
                if (out_valid_w[d] !== 1'b1 || out_state_w[d] !== E1 || in_ready_w[d] !== 1'b0) begin
                    if (ok[d])
                        $display("FAIL backpressure C=%0d cyc %0d got ov=%b os=%h rdy=%b exp 1/%h/0",
                                 cpc[d], c, out_valid_w[d], out_state_w[d], in_ready_w[d], E1);
                    ok[d] = 0;
                end
        end
        for (int d = 0; d < 3; d++) begin
            total++;
            if (ok[d]) pass_cnt++;
        end
        in_valid = 0; out_ready = 1;
        tick();
        for (int d = 0; d < 3; d++) begin
            total++;
            if (out_valid_w[d] !== 1'b0 || in_ready_w[d] !== 1'b1)
                $display("FAIL bp_release C=%0d got ov=%b rdy=%b exp 0/1",
                         cpc[d], out_valid_w[d], in_ready_w[d]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        logic seen [3];
        wait_ready();
        out_ready = 1; in_valid = 1; in_state = V1; inverse = 0;
        tick();
        in_valid = 0; rst = 1;
        tick();
        rst = 0;
        #1;
        for (int d = 0; d < 3; d++) begin
            total++;
            if (out_valid_w[d] !== 1'b0 || out_state_w[d] !== '0 || in_ready_w[d] !== 1'b1)
                $display("FAIL reset_mid C=%0d got ov=%b os=%h rdy=%b exp 0/0/1",
                         cpc[d], out_valid_w[d], out_state_w[d], in_ready_w[d]);
            else pass_cnt++;
            seen[d] = 0;
        end
        repeat (6) begin
            tick();
            for (int d = 0; d < 3; d++) if (out_valid_w[d] !== 1'b0) seen[d] = 1;
        end
        for (int d = 0; d < 3; d++) begin
            total++;
            if (seen[d]) $display("FAIL abort_pulse C=%0d got out_valid pulse exp none", cpc[d]);
            else pass_cnt++;
        end
        run_block(V2, 0, 0); check_res("after_reset", E2);
    endtask

    task automatic test_bypass();
        run_block(VB, 0, 1);
`ifdef MIXCOL_BYPASS_EN
        check_res("bypass", VB);
`else
        check_res("no_bypass", EB);
`endif
        for (int d = 0; d < 3; d++) begin
            total++;
            if (lat_r[d] !== 4 / cpc[d])
                $display("FAIL bypass_latency C=%0d got %0d exp %0d", cpc[d], lat_r[d], 4 / cpc[d]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_roundtrip();
        test_latency();
        test_backpressure();
        test_reset_mid();
        test_bypass();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mix_columns_engine.md
MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1: number of columns processed per cycle; legal values 1, 2, 4.
REQ-002 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, input block offered.
REQ-005 SHALL have port in_ready, output, 1, engine can accept a block.
REQ-006 SHALL have port in_state, input, [0:127], AES state; column i occupies bits i*32..i*32+31, and row j of column i is byte [(i*32)+(j*8)+:8].
REQ-007 SHALL have port inverse, input, 1: 0 selects forward MixColumns, 1 selects InvMixColumns.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-010 SHALL have port out_state, output, [0:127], result; uses the same byte layout as in_state.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE.
REQ-013 An accept SHALL occur on a cycle with in_valid=1 and in_ready=1.
- On accept, in_state and inverse SHALL be captured; next state SHALL be BUSY; column counter SHALL clear to 0.
REQ-014 In BUSY, each cycle SHALL transform columns counter..counter+COLS_PER_CYCLE-1 in the captured register, then advance the counter by COLS_PER_CYCLE.
REQ-015 After the cycle that processes column 3, state SHALL go to DONE.
- out_valid SHALL assert exactly 4/COLS_PER_CYCLE cycles after the accept edge.
REQ-016 In DONE, out_valid SHALL be 1 and out_state SHALL hold stable until out_ready=1.
- That handshake cycle SHALL return the FSM to IDLE; out_valid SHALL drop on the next edge.
REQ-017 out_ready SHALL be ignored outside DONE.
- in_valid, in_state and inverse SHALL be ignored outside IDLE; a mode change mid-block SHALL not affect the block.
REQ-018 There SHALL be no overlap between blocks.
- Minimum spacing between accepts SHALL be 4/COLS_PER_CYCLE+1 cycles, achieved when out_ready is held at 1.
REQ-019 Forward mode SHALL compute, for column bytes (s0,s1,s2,s3), the circulant matrix rows: {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02}.
REQ-020 Inverse mode SHALL use matrix rows: {0e 0b 0d 09}, {09 0e 0b 0d}, {0d 09 0e 0b}, {0b 0d 09 0e}.
REQ-021 All multiplication SHALL be in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11b), with XOR addition.
- xtime SHALL be a left shift, XOR 0x1b when bit 7 was set.
- The result SHALL be exactly 8 bits, with no carry retained.
REQ-022 COLS_PER_CYCLE values other than 1, 2, 4 SHALL cause an elaboration failure.

Reset
REQ-023 While rst=1 at an edge: FSM SHALL go to IDLE, out_valid SHALL be 0, out_state SHALL be 0, column counter SHALL be 0, the captured register SHALL be 0, and in_ready SHALL read 0 while rst is high.
REQ-024 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-025 Reset asserted in BUSY or DONE SHALL abort the block silently.
- No out_valid pulse SHALL follow for the aborted block.

Configuration
REQ-026 With macro MIXCOL_BYPASS_EN defined, the block SHALL add input port bypass (1 bit), captured on accept.
- A captured bypass=1 SHALL give out_state equal to the captured in_state, with identical latency and handshake.
REQ-027 Without MIXCOL_BYPASS_EN, the bypass port SHALL not exist and every block SHALL be transformed.

Verification
REQ-028 Forward column test: column db 13 53 45 with inverse=0 -> out_state column 8e 4d a1 bc.
- Column f2 0a 22 5c -> 9f dc 58 9d.
- Columns 01 01 01 01 and c6 c6 c6 c6 -> unchanged.
REQ-029 Inverse column test: column 8e 4d a1 bc with inverse=1 -> db 13 53 45.
- Random 128-bit forward result fed back in inverse mode -> original state, for each COLS_PER_CYCLE in {1,2,4}.
REQ-030 Latency test: accept at cycle T with out_ready=1 -> out_valid=1 at cycle T+4, T+2 and T+1 for COLS_PER_CYCLE 1, 2, 4 respectively.
- in_ready=1 again one cycle after the output handshake.
REQ-031 Backpressure test: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_state stable, in_ready=0.
- Meanwhile toggle in_valid, in_state and inverse -> no effect on the result.
REQ-032 Reset test: assert rst for 1 cycle mid-BUSY -> next cycle out_valid=0, out_state=0, in_ready=1.
- A new block accepted afterwards -> correct result.
REQ-033 Bypass test with MIXCOL_BYPASS_EN: bypass=1 on input db 13 53 45 (repeated) -> out_state equals the input with standard latency.
- Build without the macro -> port absent, normal transform.
